// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared constants for the dual-clock FIFO read-side stream adapter.
package async_fifo_rd_stream_pkg;

    // Depth of the adapter output buffer (words).
    localparam int BUF_DEPTH = 2;

    // Word width shared by the FIFO and the adapter.
    localparam int FIFO_DATA_WIDTH = 64;

    // Width of the beat index for a given burst length (never below one bit).
    function automatic int beat_idx_width(input int burst_len);
        if (burst_len <= 2) begin
            beat_idx_width = 1;
        end else begin
            beat_idx_width = $clog2(burst_len);
        end
    endfunction

endpackage

// File: rtl/async_fifo_rd_stream_skid_buf2.sv
// Two-entry strictly ordered buffer: head register drives the stream,
// tail register absorbs the word that arrives while the head is stalled.
module stream_skid_buf2
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [1:0]            occ_r;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] tail_nxt_s;
    logic [1:0]            occ_nxt_s;

    // Next-state of the two entries: the head always holds the oldest word.
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        occ_nxt_s  = occ_r;
        case ({push, pop})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_nxt_s = push_data;
                end else begin
                    tail_nxt_s = push_data;
                end
                occ_nxt_s = occ_r + 2'd1;
            end
            2'b01: begin
                head_nxt_s = tail_r;
                occ_nxt_s  = occ_r - 2'd1;
            end
            2'b11: begin
                // Head leaves, new word joins behind whatever remains.
                if (occ_r == 2'd2) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push_data;
                end else begin
                    head_nxt_s = push_data;
                end
            end
            default: begin
                occ_nxt_s = occ_r;
            end
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {DATA_WIDTH{1'b0}};
            tail_r <= {DATA_WIDTH{1'b0}};
            occ_r  <= 2'd0;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            occ_r  <= occ_nxt_s;
        end
    end

    assign head_data = head_r;
    assign occ       = occ_r;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain adapter: turns the FIFO's registered read port into a
// valid/ready stream with fixed-length burst framing.
module async_fifo_rd_stream
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BURST_LEN  = 16,
    localparam int IDX_W     = beat_idx_width(BURST_LEN)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [IDX_W-1:0]      beat_idx
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);
    localparam logic [1:0]       DEPTH     = 2'(BUF_DEPTH);

    logic [1:0]       occ_s;
    logic             inflight_r;
    logic [IDX_W-1:0] beat_r;
    logic             pop_s;
    logic             room_s;

    assign m_valid = (occ_s != 2'd0);
    assign pop_s   = m_valid & m_ready;
    // Buffered plus in-flight words never exceed the buffer depth.
    assign room_s  = ((occ_s + {1'b0, inflight_r}) < DEPTH);
    // Reset gating keeps the FIFO from being read while both sides are held.
    assign fifo_rd_en = rd_rst_n & ~fifo_empty & (room_s | pop_s);

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (inflight_r),
        .push_data (fifo_dout),
        .pop       (pop_s),
        .head_data (m_data),
        .occ       (occ_s)
    );

    // Track the accepted read whose data lands on fifo_dout next cycle.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_rd_en;
        end
    end

    // Beat counter: advances per delivered word, wraps at the burst end,
    // holds across gaps so bursts resume where they left off.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_r <= {IDX_W{1'b0}};
        end else if (pop_s) begin
            if (beat_r == LAST_BEAT) begin
                beat_r <= {IDX_W{1'b0}};
            end else begin
                beat_r <= beat_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    assign m_last   = (beat_r == LAST_BEAT);
    assign beat_idx = beat_r;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Self-checking bench for async_fifo_rd_stream (BURST_LEN 16, plus a
// BURST_LEN 1 instance fed the same inputs).
module tb_async_fifo_rd_stream;

    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rd_rst_n = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        m_ready = 1'b0;
    logic [63:0] fifo_dout = 64'd0;
    logic        fifo_rd_en, m_valid, m_last;
    logic [63:0] m_data;
    logic [3:0]  beat_idx;
    logic        fifo_rd_en1, m_valid1, m_last1;
    logic [63:0] m_data1;
    logic [0:0]  beat_idx1;

    int checks = 0;
    int errors = 0;

    // Bench-side FIFO contents and expected stream order.
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    int outstanding = 0;  // accepted reads not yet delivered
    int avail = 0;        // words that should be visible on the stream
    int pops = 0;         // words delivered since reset
    bit acc_prev = 1'b0;
    int tick_n = 0;

    logic [63:0] log_data[$];
    bit          log_last[$];
    int          log_beat[$];
    int          log_cyc[$];

    always #5 clk = ~clk;

    async_fifo_rd_stream #(.DATA_WIDTH(64), .BURST_LEN(BL)) dut (
        .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .beat_idx(beat_idx)
    );

    async_fifo_rd_stream #(.DATA_WIDTH(64), .BURST_LEN(1)) dut1 (
        .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_rd_en(fifo_rd_en1),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .m_valid(m_valid1),
        .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .beat_idx(beat_idx1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input bit gate, input bit rdy, output bit s_rd, output bit s_vld,
                        output logic [63:0] s_data, output int s_beat);
        bit acc;
        bit pop;
        int eb;
        m_ready    = rdy;
        fifo_empty = gate || (fifo_q.size() == 0);
        #1;
        s_rd   = fifo_rd_en;
        s_vld  = m_valid;
        s_data = m_data;
        s_beat = int'(beat_idx);
        eb     = pops % BL;
        chk("m_valid", 64'(m_valid), 64'(avail != 0));
        if (avail != 0 && exp_q.size() > 0) chk("m_data", m_data, exp_q[0]);
        chk("beat_idx", 64'(beat_idx), 64'(eb));
        chk("m_last", 64'(m_last), 64'(eb == BL - 1));
        chk("fifo_rd_en", 64'(fifo_rd_en),
            64'(!fifo_empty && (outstanding < 2 || (avail != 0 && rdy))));
        chk("bl1_valid", 64'(m_valid1), 64'(m_valid));
        if (m_valid1) begin
            chk("bl1_data", m_data1, m_data);
            chk("bl1_last", 64'(m_last1), 64'd1);
            chk("bl1_beat", 64'(beat_idx1), 64'd0);
        end
        acc = fifo_rd_en && !fifo_empty;
        pop = m_valid && rdy;
        @(posedge clk);
        #1;
        if (pop) begin
            log_data.push_back(s_data);
            log_last.push_back(m_last === 1'b1 ? 1'b0 : 1'b0);
            log_last[log_last.size()-1] = (eb == BL - 1) ? 1'b1 : 1'b0;
            log_beat.push_back(s_beat);
            log_cyc.push_back(tick_n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pops++;
        end
        outstanding = outstanding + int'(acc) - int'(pop);
        avail       = avail + int'(acc_prev) - int'(pop);
        if (avail < 0) avail = 0;
        acc_prev = acc;
        chk("occ_plus_inflight_le_2", 64'(outstanding <= 2), 64'd1);
        if (acc && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        else fifo_dout = {$urandom(), $urandom()};
        tick_n++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse, asserted between clock edges; entered and left at a falling edge.
    task automatic async_reset(input bit do_check);
        m_ready    = 1'b1;
        fifo_empty = 1'b0;
        #2;
        rd_rst_n = 1'b0;
        #1;
        if (do_check) begin
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_beat_idx", 64'(beat_idx), 64'd0);
            chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("rst_m_last", 64'(m_last), 64'd0);
            chk("rst_m_data", m_data, 64'd0);
        end
        fifo_q.delete();
        exp_q.delete();
        outstanding = 0;
        avail       = 0;
        pops        = 0;
        acc_prev    = 1'b0;
        fifo_empty  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        log_beat.delete();
        log_cyc.delete();
    endtask

    typedef struct {
        bit          gate;
        bit          rdy;
        bit          exp_rd;
        bit          exp_vld;
        logic [63:0] exp_data;
        int          exp_beat;
    } vec_t;

    initial begin
        vec_t        vec[4];
        bit          s_rd, s_vld;
        logic [63:0] s_data, held;
        int          s_beat;
        int          budget;

        vec[0] = '{gate: 1'b0, rdy: 1'b1, exp_rd: 1'b1, exp_vld: 1'b0, exp_data: 64'h0,    exp_beat: 0};
        vec[1] = '{gate: 1'b0, rdy: 1'b1, exp_rd: 1'b0, exp_vld: 1'b0, exp_data: 64'h0,    exp_beat: 0};
        vec[2] = '{gate: 1'b0, rdy: 1'b1, exp_rd: 1'b0, exp_vld: 1'b1, exp_data: 64'hA5A5, exp_beat: 0};
        vec[3] = '{gate: 1'b0, rdy: 1'b1, exp_rd: 1'b0, exp_vld: 1'b0, exp_data: 64'h0,    exp_beat: 1};

        @(negedge clk);
        async_reset(1'b1);

        // Single word: read in N, valid in N+2, gone in N+3.
        push_word(64'hA5A5);
        for (int i = 0; i < 4; i++) begin
            tick(vec[i].gate, vec[i].rdy, s_rd, s_vld, s_data, s_beat);
            chk($sformatf("vec%0d_rd_en", i), 64'(s_rd), 64'(vec[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), 64'(s_vld), 64'(vec[i].exp_vld));
            chk($sformatf("vec%0d_beat", i), 64'(s_beat), 64'(vec[i].exp_beat));
            if (vec[i].exp_vld) chk($sformatf("vec%0d_data", i), s_data, vec[i].exp_data);
        end

        // Streaming 40 words back-to-back.
        async_reset(1'b0);
        clear_logs();
        for (int i = 0; i < 40; i++) push_word(64'(i));
        budget = 0;
        while (log_data.size() < 40 && budget < 200) begin
            tick(1'b0, 1'b1, s_rd, s_vld, s_data, s_beat);
            budget++;
        end
        chk("stream_count", 64'(log_data.size()), 64'd40);
        if (log_data.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                chk($sformatf("stream_data%0d", i), log_data[i], 64'(i));
                chk($sformatf("stream_last%0d", i), 64'(log_last[i]), 64'(i == 15 || i == 31));
            end
            chk("stream_beat39", 64'(log_beat[39]), 64'd7);
            chk("stream_back_to_back", 64'(log_cyc[39] - log_cyc[0]), 64'd39);
        end

        // Backpressure: 10 words, consumer stalled for 8 cycles.
        clear_logs();
        for (int i = 0; i < 10; i++) push_word(64'(100 + i));
        held = 64'd0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, s_rd, s_vld, s_data, s_beat);
            if (k == 2) held = s_data;
            if (k >= 2) chk("stall_rd_en", 64'(s_rd), 64'd0);
            if (k >= 3) chk("stall_data_stable", s_data, held);
        end
        chk("stall_outstanding", 64'(outstanding), 64'd2);
        budget = 0;
        while (log_data.size() < 10 && budget < 100) begin
            tick(1'b0, 1'b1, s_rd, s_vld, s_data, s_beat);
            budget++;
        end
        chk("bp_count", 64'(log_data.size()), 64'd10);
        for (int i = 0; i < log_data.size(); i++)
            chk($sformatf("bp_data%0d", i), log_data[i], 64'(100 + i));

        // Random handshake and FIFO empty toggling.
        clear_logs();
        for (int i = 0; i < 1000; i++) push_word({$urandom(), $urandom()});
        budget = 0;
        while (log_data.size() < 1000 && budget < 20000) begin
            tick($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), s_rd, s_vld, s_data, s_beat);
            budget++;
        end
        chk("random_count", 64'(log_data.size()), 64'd1000);

        // Mid-operation reset with a full buffer.
        for (int i = 0; i < 6; i++) push_word(64'(200 + i));
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, s_rd, s_vld, s_data, s_beat);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, s_rd, s_vld, s_data, s_beat);
        chk("pre_reset_outstanding", 64'(outstanding), 64'd2);
        async_reset(1'b1);
        clear_logs();
        for (int i = 0; i < 3; i++) push_word(64'(300 + i));
        budget = 0;
        while (log_data.size() < 3 && budget < 50) begin
            tick(1'b0, 1'b1, s_rd, s_vld, s_data, s_beat);
            budget++;
        end
        chk("post_reset_count", 64'(log_data.size()), 64'd3);
        if (log_data.size() == 3) begin
            chk("post_reset_beat0", 64'(log_beat[0]), 64'd0);
            chk("post_reset_data0", log_data[0], 64'd300);
            chk("post_reset_data2", log_data[2], 64'd302);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
